// File: rtl/bat_pkg.sv
// Shared widths, register indices and instruction encodings for the BatAmateur
// controller/datapath pair.
package bat_pkg;

  localparam int ADDR_W    = 8;
  localparam int WORD_W    = 16;
  localparam int REG_W     = 8;
  localparam int NREGS     = 8;
  localparam int RAM_DEPTH = 2 ** ADDR_W;

  localparam int REG_IDX_A   = 0;
  localparam int REG_IDX_B   = 1;
  localparam int REG_IDX_OUT = 7;

  // Bus source slots; register i sits at SRC_REG0 + i.
  localparam int SRC_PC   = 0;
  localparam int SRC_RAM  = 1;
  localparam int SRC_IR   = 2;
  localparam int SRC_ALU  = 3;
  localparam int SRC_REG0 = 4;
  localparam int NSRC     = SRC_REG0 + NREGS;

  localparam logic [WORD_W-1:0] IR_RESET = 16'hF000;

  // Opcode lives in IR[15:12]; IR[7:0] is the address/immediate field.
  typedef enum logic [3:0] {
    OP_MOV = 4'h0,
    OP_ADD = 4'h1,
    OP_SUB = 4'h2,
    OP_INC = 4'h3,
    OP_LDA = 4'h4,
    OP_STA = 4'h5,
    OP_JMP = 4'h6,
    OP_JZ  = 4'h7,
    OP_OUT = 4'h8,
    OP_HLT = 4'hE,
    OP_NOP = 4'hF
  } bat_opcode_e;

  function automatic bat_opcode_e ir_opcode(input logic [WORD_W-1:0] ir);
    return bat_opcode_e'(ir[15:12]);
  endfunction

endpackage

// File: rtl/bat_bus_mux.sv
// OR-merging shared bus: combines every enabled source and flags when more
// than one source drives in the same cycle.
module bat_bus_mux #(
  parameter int NSRC = 12,
  parameter int W    = 16
) (
  input  logic [NSRC-1:0]        drv,
  input  logic [NSRC-1:0][W-1:0] src,
  output logic [W-1:0]           bus,
  output logic                   contention
);

  always_comb begin
    bus = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (drv[i]) bus = bus | src[i];
    end
    // Clearing the lowest set bit leaves something only if >1 bit was set.
    contention = |(drv & (drv - {{(NSRC-1){1'b0}}, 1'b1}));
  end

endmodule

// File: rtl/bat_datapath.sv
// BatAmateur datapath: shared bus, PC, MAR, IR, register file and program RAM,
// driven by the controller's per-cycle strobes.
module bat_datapath
  import bat_pkg::*;
(
  input  logic              CLK,
  input  logic              RST,
  input  logic              PC_INC,
  input  logic              PC_RW,
  input  logic              PC_EN,
  input  logic              MAR_LOAD,
  input  logic              MAR_EN,
  input  logic              RAM_RW,
  input  logic              RAM_EN,
  input  logic              IR_LOAD,
  input  logic              IR_EN,
  input  logic [NREGS-1:0]  REGS_INC,
  input  logic [NREGS-1:0]  REGS_RW,
  input  logic [NREGS-1:0]  REGS_EN,
  input  logic              ALU_EN,
  input  logic [REG_W-1:0]  ALU_Y,
  input  logic              PROG_WE,
  input  logic [ADDR_W-1:0] PROG_ADDR,
  input  logic [WORD_W-1:0] PROG_DATA,
  output logic [WORD_W-1:0] INSTR,
  output logic [REG_W-1:0]  REG_A,
  output logic [REG_W-1:0]  REG_B,
  output logic [REG_W-1:0]  OUT_PORT,
  output logic [WORD_W-1:0] BUS,
  output logic              BUS_ERR
);

  logic [ADDR_W-1:0]             pc_q;
  logic [ADDR_W-1:0]             mar_q;
  logic [WORD_W-1:0]             ir_q;
  logic [NREGS-1:0][REG_W-1:0]   regs_q;
  logic                          bus_err_q;
  logic [WORD_W-1:0]             ram [0:RAM_DEPTH-1];

  logic [WORD_W-1:0]             ram_rd;
  logic                          ram_wr;
  logic [NSRC-1:0]               drv;
  logic [NSRC-1:0][WORD_W-1:0]   src;
  logic                          bus_cont;

  // RAM reads the MAR as it stands before this edge's MAR_LOAD.
  assign ram_rd = ram[mar_q];
  assign ram_wr = RAM_EN && !RAM_RW && MAR_EN;

  always_comb begin
    drv = '0;
    src = '0;
    drv[SRC_PC]  = PC_EN && PC_RW;
    src[SRC_PC]  = {{(WORD_W-ADDR_W){1'b0}}, pc_q};
    drv[SRC_RAM] = RAM_EN && RAM_RW && MAR_EN;
    src[SRC_RAM] = ram_rd;
    drv[SRC_IR]  = IR_EN;
    src[SRC_IR]  = {{(WORD_W-8){1'b0}}, ir_q[7:0]};
    drv[SRC_ALU] = ALU_EN;
    src[SRC_ALU] = {{(WORD_W-REG_W){1'b0}}, ALU_Y};
    for (int i = 0; i < NREGS; i++) begin
      drv[SRC_REG0+i] = REGS_EN[i] && REGS_RW[i];
      src[SRC_REG0+i] = {{(WORD_W-REG_W){1'b0}}, regs_q[i]};
    end
  end

  bat_bus_mux #(
    .NSRC (NSRC),
    .W    (WORD_W)
  ) u_bus_mux (
    .drv        (drv),
    .src        (src),
    .bus        (BUS),
    .contention (bus_cont)
  );

  always_ff @(posedge CLK) begin
    if (!RST) begin
      pc_q      <= '0;
      mar_q     <= '0;
      ir_q      <= IR_RESET;
      regs_q    <= '0;
      bus_err_q <= 1'b0;
    end else begin
      if (PC_EN && !PC_RW) pc_q <= BUS[ADDR_W-1:0];
      else if (PC_INC)     pc_q <= pc_q + ADDR_W'(1);

      if (MAR_LOAD) mar_q <= BUS[ADDR_W-1:0];
      if (IR_LOAD)  ir_q  <= BUS;
      if (bus_cont) bus_err_q <= 1'b1;

      for (int i = 0; i < NREGS; i++) begin
        if (REGS_EN[i] && !REGS_RW[i]) regs_q[i] <= BUS[REG_W-1:0];
        else if (REGS_INC[i])          regs_q[i] <= regs_q[i] + REG_W'(1);
      end
    end
  end

  // RAM has no reset; the program loader owns it while RST is low.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      if (PROG_WE) ram[PROG_ADDR] <= PROG_DATA;
    end else if (ram_wr) begin
      ram[mar_q] <= BUS;
    end
  end

  assign INSTR    = ir_q;
  assign REG_A    = regs_q[REG_IDX_A];
  assign REG_B    = regs_q[REG_IDX_B];
  assign OUT_PORT = regs_q[REG_IDX_OUT];
  assign BUS_ERR  = bus_err_q;

endmodule

// File: tb/tb_bat_datapath.sv
// Directed vector bench for bat_datapath: program load, fetch/jump/load/MOV/INC
// sequences, RAM write/readback, PC wrap, bus contention and mid-run reset.
module tb_bat_datapath;
  import bat_pkg::*;

  // Control mask bits for the single-bit strobes.
  localparam logic [9:0] C_PC_INC   = 10'h001;
  localparam logic [9:0] C_PC_RW    = 10'h002;
  localparam logic [9:0] C_PC_EN    = 10'h004;
  localparam logic [9:0] C_MAR_LOAD = 10'h008;
  localparam logic [9:0] C_MAR_EN   = 10'h010;
  localparam logic [9:0] C_RAM_RW   = 10'h020;
  localparam logic [9:0] C_RAM_EN   = 10'h040;
  localparam logic [9:0] C_IR_LOAD  = 10'h080;
  localparam logic [9:0] C_IR_EN    = 10'h100;
  localparam logic [9:0] C_ALU_EN   = 10'h200;

  typedef struct {
    logic [9:0]        ctl;
    logic [NREGS-1:0]  rinc;
    logic [NREGS-1:0]  rrw;
    logic [NREGS-1:0]  ren;
    logic [REG_W-1:0]  alu_y;
    logic [WORD_W-1:0] exp_bus;
    logic [WORD_W-1:0] exp_instr;
    logic [REG_W-1:0]  exp_a;
    logic [REG_W-1:0]  exp_b;
    logic [REG_W-1:0]  exp_out;
    logic              exp_err;
  } vec_t;

  logic              CLK;
  logic              RST;
  logic              PC_INC, PC_RW, PC_EN, MAR_LOAD, MAR_EN;
  logic              RAM_RW, RAM_EN, IR_LOAD, IR_EN, ALU_EN;
  logic [NREGS-1:0]  REGS_INC, REGS_RW, REGS_EN;
  logic [REG_W-1:0]  ALU_Y;
  logic              PROG_WE;
  logic [ADDR_W-1:0] PROG_ADDR;
  logic [WORD_W-1:0] PROG_DATA;
  logic [WORD_W-1:0] INSTR;
  logic [REG_W-1:0]  REG_A, REG_B, OUT_PORT;
  logic [WORD_W-1:0] BUS;
  logic              BUS_ERR;

  int tests_run;
  int tests_failed;
  vec_t vecs[$];

  bat_datapath dut (
    .CLK       (CLK),
    .RST       (RST),
    .PC_INC    (PC_INC),
    .PC_RW     (PC_RW),
    .PC_EN     (PC_EN),
    .MAR_LOAD  (MAR_LOAD),
    .MAR_EN    (MAR_EN),
    .RAM_RW    (RAM_RW),
    .RAM_EN    (RAM_EN),
    .IR_LOAD   (IR_LOAD),
    .IR_EN     (IR_EN),
    .REGS_INC  (REGS_INC),
    .REGS_RW   (REGS_RW),
    .REGS_EN   (REGS_EN),
    .ALU_EN    (ALU_EN),
    .ALU_Y     (ALU_Y),
    .PROG_WE   (PROG_WE),
    .PROG_ADDR (PROG_ADDR),
    .PROG_DATA (PROG_DATA),
    .INSTR     (INSTR),
    .REG_A     (REG_A),
    .REG_B     (REG_B),
    .OUT_PORT  (OUT_PORT),
    .BUS       (BUS),
    .BUS_ERR   (BUS_ERR)
  );

  // Clock / reset
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  function automatic vec_t mk(input logic [9:0] ctl, input logic [7:0] rinc,
                              input logic [7:0] rrw, input logic [7:0] ren,
                              input logic [7:0] alu_y, input logic [15:0] bus,
                              input logic [15:0] instr, input logic [7:0] a,
                              input logic [7:0] b, input logic [7:0] o,
                              input logic err);
    vec_t v;
    v.ctl = ctl; v.rinc = rinc; v.rrw = rrw; v.ren = ren; v.alu_y = alu_y;
    v.exp_bus = bus; v.exp_instr = instr; v.exp_a = a; v.exp_b = b;
    v.exp_out = o; v.exp_err = err;
    return v;
  endfunction

  // Driver tasks
  task automatic drive_ctl(input logic [9:0] ctl, input logic [7:0] rinc,
                           input logic [7:0] rrw, input logic [7:0] ren,
                           input logic [7:0] alu_y);
    PC_INC   = ctl[0];
    PC_RW    = ctl[1];
    PC_EN    = ctl[2];
    MAR_LOAD = ctl[3];
    MAR_EN   = ctl[4];
    RAM_RW   = ctl[5];
    RAM_EN   = ctl[6];
    IR_LOAD  = ctl[7];
    IR_EN    = ctl[8];
    ALU_EN   = ctl[9];
    REGS_INC = rinc;
    REGS_RW  = rrw;
    REGS_EN  = ren;
    ALU_Y    = alu_y;
  endtask

  // Scoreboard compare
  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic [15:0] instr, input logic [7:0] a,
                           input logic [7:0] b, input logic [7:0] o, input logic err);
    chk({tag, " INSTR"},    INSTR, instr);
    chk({tag, " REG_A"},    {8'h00, REG_A}, {8'h00, a});
    chk({tag, " REG_B"},    {8'h00, REG_B}, {8'h00, b});
    chk({tag, " OUT_PORT"}, {8'h00, OUT_PORT}, {8'h00, o});
    chk({tag, " BUS_ERR"},  {15'h0, BUS_ERR}, {15'h0, err});
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    RST       = 1'b0;
    PROG_WE   = 1'b0;
    PROG_ADDR = '0;
    PROG_DATA = '0;
    drive_ctl('0, '0, '0, '0, '0);

    //           ctl                                          rinc   rrw    ren    alu    bus       instr     A      B      OUT    err
    vecs.push_back(mk(C_PC_EN|C_PC_RW|C_MAR_LOAD,                 8'h00, 8'h00, 8'h00, 8'h00, 16'h0000, 16'hF000, 8'h00, 8'h00, 8'h00, 1'b0));
    vecs.push_back(mk(C_RAM_EN|C_RAM_RW|C_MAR_EN|C_IR_LOAD|C_PC_INC, 8'h00, 8'h00, 8'h00, 8'h00, 16'h4005, 16'h4005, 8'h00, 8'h00, 8'h00, 1'b0));
    vecs.push_back(mk(C_PC_EN|C_PC_RW,                            8'h00, 8'h00, 8'h00, 8'h00, 16'h0001, 16'h4005, 8'h00, 8'h00, 8'h00, 1'b0));
    vecs.push_back(mk(C_IR_EN|C_PC_EN|C_PC_INC,                   8'h00, 8'h00, 8'h00, 8'h00, 16'h0005, 16'h4005, 8'h00, 8'h00, 8'h00, 1'b0));
    vecs.push_back(mk(C_PC_EN|C_PC_RW,                            8'h00, 8'h00, 8'h00, 8'h00, 16'h0005, 16'h4005, 8'h00, 8'h00, 8'h00, 1'b0));
    vecs.push_back(mk(C_IR_EN|C_MAR_LOAD,                         8'h00, 8'h00, 8'h00, 8'h00, 16'h0005, 16'h4005, 8'h00, 8'h00, 8'h00, 1'b0));
    vecs.push_back(mk(C_RAM_EN|C_RAM_RW|C_MAR_EN,                 8'h00, 8'h00, 8'h01, 8'h00, 16'h0033, 16'h4005, 8'h33, 8'h00, 8'h00, 1'b0));
    vecs.push_back(mk(10'h000,                                    8'h00, 8'h01, 8'h81, 8'h00, 16'h0033, 16'h4005, 8'h33, 8'h00, 8'h33, 1'b0));
    vecs.push_back(mk(C_ALU_EN,                                   8'h00, 8'h00, 8'h02, 8'hFF, 16'h00FF, 16'h4005, 8'h33, 8'hFF, 8'h33, 1'b0));
    vecs.push_back(mk(10'h000,                                    8'h02, 8'h00, 8'h00, 8'h00, 16'h0000, 16'h4005, 8'h33, 8'h00, 8'h33, 1'b0));
    vecs.push_back(mk(C_ALU_EN,                                   8'h00, 8'h00, 8'h02, 8'h5A, 16'h005A, 16'h4005, 8'h33, 8'h5A, 8'h33, 1'b0));
    vecs.push_back(mk(10'h000,                                    8'h00, 8'h02, 8'h02, 8'h00, 16'h005A, 16'h4005, 8'h33, 8'h5A, 8'h33, 1'b0));
    vecs.push_back(mk(C_ALU_EN,                                   8'h01, 8'h00, 8'h01, 8'h10, 16'h0010, 16'h4005, 8'h10, 8'h5A, 8'h33, 1'b0));
    vecs.push_back(mk(10'h000,                                    8'h01, 8'h00, 8'h00, 8'h00, 16'h0000, 16'h4005, 8'h11, 8'h5A, 8'h33, 1'b0));
    vecs.push_back(mk(C_ALU_EN|C_RAM_EN|C_MAR_EN,                 8'h00, 8'h00, 8'h00, 8'h77, 16'h0077, 16'h4005, 8'h11, 8'h5A, 8'h33, 1'b0));
    vecs.push_back(mk(C_RAM_EN|C_RAM_RW|C_MAR_EN,                 8'h00, 8'h00, 8'h01, 8'h00, 16'h0077, 16'h4005, 8'h77, 8'h5A, 8'h33, 1'b0));
    vecs.push_back(mk(C_RAM_EN|C_RAM_RW,                          8'h00, 8'h00, 8'h01, 8'h00, 16'h0000, 16'h4005, 8'h00, 8'h5A, 8'h33, 1'b0));
    vecs.push_back(mk(C_ALU_EN|C_PC_EN,                           8'h00, 8'h00, 8'h00, 8'hFF, 16'h00FF, 16'h4005, 8'h00, 8'h5A, 8'h33, 1'b0));
    vecs.push_back(mk(C_PC_INC,                                   8'h00, 8'h00, 8'h00, 8'h00, 16'h0000, 16'h4005, 8'h00, 8'h5A, 8'h33, 1'b0));
    vecs.push_back(mk(C_PC_EN|C_PC_RW,                            8'h00, 8'h00, 8'h00, 8'h00, 16'h0000, 16'h4005, 8'h00, 8'h5A, 8'h33, 1'b0));
    vecs.push_back(mk(C_PC_INC,                                   8'h00, 8'h00, 8'h00, 8'h00, 16'h0000, 16'h4005, 8'h00, 8'h5A, 8'h33, 1'b0));
    vecs.push_back(mk(C_PC_EN|C_PC_RW,                            8'h00, 8'h00, 8'h00, 8'h00, 16'h0001, 16'h4005, 8'h00, 8'h5A, 8'h33, 1'b0));
    vecs.push_back(mk(C_ALU_EN|C_PC_EN,                           8'h00, 8'h00, 8'h00, 8'h05, 16'h0005, 16'h4005, 8'h00, 8'h5A, 8'h33, 1'b0));
    vecs.push_back(mk(C_ALU_EN|C_IR_LOAD,                         8'h00, 8'h00, 8'h00, 8'h0A, 16'h000A, 16'h000A, 8'h00, 8'h5A, 8'h33, 1'b0));
    vecs.push_back(mk(C_PC_EN|C_PC_RW|C_IR_EN,                    8'h00, 8'h00, 8'h00, 8'h00, 16'h000F, 16'h000A, 8'h00, 8'h5A, 8'h33, 1'b1));
    vecs.push_back(mk(10'h000,                                    8'h00, 8'h00, 8'h00, 8'h00, 16'h0000, 16'h000A, 8'h00, 8'h5A, 8'h33, 1'b1));

    // Program load under reset
    @(negedge CLK);
    PROG_WE = 1'b1; PROG_ADDR = 8'h00; PROG_DATA = 16'h4005;
    @(negedge CLK);
    PROG_ADDR = 8'h05; PROG_DATA = 16'h0033;
    @(negedge CLK);
    PROG_WE = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    #1;
    chk_state("reset", 16'hF000, 8'h00, 8'h00, 8'h00, 1'b0);

    // Table-driven vectors: bus checked before the edge, state after it
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge CLK);
      drive_ctl(vecs[i].ctl, vecs[i].rinc, vecs[i].rrw, vecs[i].ren, vecs[i].alu_y);
      #1;
      chk($sformatf("v%0d BUS", i), BUS, vecs[i].exp_bus);
      @(posedge CLK);
      #1;
      chk_state($sformatf("v%0d", i), vecs[i].exp_instr, vecs[i].exp_a,
                vecs[i].exp_b, vecs[i].exp_out, vecs[i].exp_err);
    end

    // Reset mid-instruction: strobes ignored, state cleared, sticky error cleared
    @(negedge CLK);
    RST = 1'b0;
    drive_ctl(C_ALU_EN|C_PC_INC|C_IR_LOAD, 8'h80, 8'h00, 8'h03, 8'hAA);
    @(posedge CLK);
    #1;
    chk_state("midrst", 16'hF000, 8'h00, 8'h00, 8'h00, 1'b0);

    @(negedge CLK);
    RST = 1'b1;
    drive_ctl(C_PC_EN|C_PC_RW, 8'h00, 8'h00, 8'h00, 8'h00);
    #1;
    chk("midrst PC", BUS, 16'h0000);
    @(negedge CLK);
    drive_ctl(C_RAM_EN|C_RAM_RW|C_MAR_EN, 8'h00, 8'h00, 8'h00, 8'h00);
    #1;
    chk("midrst RAM0 kept", BUS, 16'h4005);
    @(negedge CLK);
    drive_ctl(C_IR_EN|C_MAR_LOAD, 8'h00, 8'h00, 8'h00, 8'h00);
    @(negedge CLK);
    drive_ctl(C_RAM_EN|C_RAM_RW|C_MAR_EN, 8'h00, 8'h00, 8'h00, 8'h00);
    #1;
    chk("midrst RAM0 via IR addr", BUS, 16'h4005);
    @(posedge CLK);
    #1;
    chk_state("end", 16'hF000, 8'h00, 8'h00, 8'h00, 1'b0);

    @(negedge CLK);
    drive_ctl('0, '0, '0, '0, '0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/bat_datapath.md
Name: bat_datapath

Overview:
- Responder side of the BatAmateur controller interface. It consumes the controller's per-cycle strobes (PC, MAR, RAM, IR, register file, ALU enable) and implements the shared bus, PC, MAR, IR, 8-entry register file and program RAM.
- Returns INSTR to the controller and REG_A/REG_B to the external ALU.
- The controller changes its strobes on negedge CLK. This block samples and updates state on posedge CLK.

Parameters:
- ADDR_W, 8, PC/MAR/RAM address width (RAM depth 2**ADDR_W)
- WORD_W, 16, bus, RAM word and IR width
- REG_W, 8, register-file, ALU and OUT width
- NREGS, 8, register count; index 0=A, 1=B, 7=OUT

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  reset, synchronous, active-low
- PC_INC  in  1  increment PC
- PC_RW  in  1  1 = PC drives bus, 0 = PC loads from bus (gated by PC_EN)
- PC_EN  in  1  PC bus enable
- MAR_LOAD  in  1  MAR loads bus[ADDR_W-1:0]
- MAR_EN  in  1  MAR addresses RAM; 0 blocks all RAM access
- RAM_RW  in  1  1 = read RAM[MAR] onto bus, 0 = write bus into RAM[MAR]
- RAM_EN  in  1  RAM enable
- IR_LOAD  in  1  IR loads full bus word
- IR_EN  in  1  IR drives {0, IR[7:0]} (address field) onto bus
- REGS_INC  in  NREGS  per-register increment
- REGS_RW  in  NREGS  per-register 1 = drive, 0 = load
- REGS_EN  in  NREGS  per-register bus enable
- ALU_EN  in  1  ALU_Y drives bus (zero-extended)
- ALU_Y  in  REG_W  external ALU result
- PROG_WE  in  1  program-load write strobe, honoured only while RST=0
- PROG_ADDR  in  ADDR_W  program-load address
- PROG_DATA  in  WORD_W  program-load data
- INSTR  out  WORD_W  IR contents
- REG_A  out  REG_W  register 0
- REG_B  out  REG_W  register 1
- OUT_PORT  out  REG_W  register 7
- BUS  out  WORD_W  current bus value (combinational, debug)
- BUS_ERR  out  1  sticky bus-contention flag

Behaviour:
- Reset values (RST=0 at posedge):
  - PC=0, MAR=0, IR=16'hF000 (NOP encoding), all registers=0, BUS_ERR=0.
  - RAM is not cleared. PROG_WE=1 writes RAM[PROG_ADDR]=PROG_DATA on that edge.
  - All controller strobes are ignored during reset.
- Bus drivers: PC (EN&RW), RAM (EN&RW&MAR_EN), IR (IR_EN), reg i (EN[i]&RW[i]), ALU (ALU_EN).
- Bus value is combinational, same cycle:
  - 8-bit sources are zero-extended.
  - Zero drivers: bus = 0.
  - Multiple drivers: bus = bitwise OR of all drivers, and BUS_ERR is set at the next posedge. It stays set until reset.
- Loads happen at posedge and use the pre-edge bus, i.e. read-before-write. Zero-latency transfer: a source driven in cycle N lands in the destination at the end of cycle N.
- PC:
  - Load (EN&!RW) has priority over INC.
  - INC adds 1 mod 2**ADDR_W.
  - Load takes bus[ADDR_W-1:0].
- MAR: MAR_LOAD loads bus[ADDR_W-1:0]. Independent of MAR_EN.
- RAM: write on EN&!RW&MAR_EN. Read is combinational from RAM[MAR] (current MAR, not the value being loaded this cycle).
- IR: IR_LOAD loads the whole bus word.
- Register i:
  - Load (EN&!RW) has priority over INC.
  - INC wraps 8'hFF→8'h00.
  - INC with EN=0 is legal (controller INC form).
  - Load takes bus[REG_W-1:0].
- Self-transfer (reg i EN with RW=1 alone) is a plain drive with no state change.
- Outputs REG_A, REG_B, OUT_PORT and INSTR are registered state, with no added latency.
- Reset asserted mid-instruction: all state is returned to reset values at that edge. RAM contents are preserved.

Decomposition:
- Package bat_pkg holds:
  - widths ADDR_W, WORD_W, REG_W, NREGS
  - register indices REG_IDX_A=0, REG_IDX_B=1, REG_IDX_OUT=7
  - IR_RESET=16'hF000
  - instruction opcode constants shared with the controller
- One sub-module, bat_bus_mux: takes the driver-valid vector plus source words and produces the OR-merged bus and a contention (>1 driver) flag.
- Registers and RAM stay in bat_datapath.

Test Plan:
- Program load: RST=0, PROG_WE writes RAM[0]=16'h4005, RAM[5]=16'h0033 → after release, PC=0, IR=16'hF000, BUS_ERR=0.
- Fetch:
  - PC_EN/PC_RW=1 + MAR_LOAD → MAR=0.
  - Next cycle RAM_EN/RW=1 + IR_LOAD + PC_INC → INSTR=16'h4005, PC=1.
- Jump: IR_EN + PC_EN/PC_RW=0 + PC_INC=1 in the same cycle → PC=5, because load beats INC.
- Load A from RAM:
  - IR_EN + MAR_LOAD → MAR=5.
  - Then RAM_EN/RW=1 + REGS_EN[0]/RW[0]=0 → REG_A=8'h33.
- MOV/INC:
  - REGS_EN[7]/RW[7]=0 with REGS_EN[0]/RW[0]=1 → OUT_PORT=8'h33.
  - REGS_INC[1]=1 on B=8'hFF → B=8'h00.
  - ALU_EN with ALU_Y=8'h5A + load B → REG_B=8'h5A.
- Contention: PC_EN/RW=1 (PC=5) and IR_EN (IR[7:0]=8'h0A) together → BUS=16'h000F, BUS_ERR=1 next edge. It stays 1 until RST=0, then clears.
